issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  Slot allocator and issue scheduler for the instruction buffer whose dependency table is the IRT.
//  Hands out free buffer slots and captures each new instruction's dependency vector (IRT current_dept).
//  Issues, one per cycle, a slot whose producers have all completed, and retires slots on completion.
//  Sits between decode (alloc side) and the execution units (issue/done side).
// PARAMETERS
//  bs      32  buffer slots; must match the IRT bs
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               synchronous, active-high reset
//  alloc_valid  in   1               decode presents an instruction
//  alloc_ready  out  1               at least one FREE slot exists
//  alloc_index  out  $clog2(bs)      lowest-index FREE slot; drives IRT buffer_index
//  alloc_dept   in   [0:bs-1]        dependency vector for the incoming instruction; bit j = slot j
//  issue_valid  out  1               issue_index holds a dispatchable slot
//  issue_ready  in   1               execution unit accepts
//  issue_index  out  $clog2(bs)      slot being issued
//  done_valid   in   1               execution completed for done_index
//  done_index   in   $clog2(bs)      completing slot
//  occupancy    out  $clog2(bs)+1    number of non-FREE slots
// BEHAVIOUR
//  - Per-slot state: FREE -> WAIT (alloc fire) -> ISSUED (loaded into issue reg) -> FREE (done).
//  - Per-slot dep row dep[i][0:bs-1].
//    - On alloc fire into slot k: dep[k] = alloc_dept & live & ~onehot(k) & ~(done_valid ? onehot(done_index) : 0).
//    - live = slots not FREE before the edge.
//  - Alloc fire = alloc_valid & alloc_ready.
//    - alloc_index/alloc_ready decode from registered state only; a slot freed by done this cycle is usable next cycle.
//    - alloc_index is 0 when full (don't care).
//  - Done with done_valid=1 and slot ISSUED:
//    - That slot -> FREE.
//    - Column done_index is cleared in every dep row at the same edge.
//    - Done for a non-ISSUED slot is ignored (no state change).
//  - Candidate set = WAIT slots with an all-zero dep row, evaluated on registered state.
//  - Issue register loads when (!issue_valid) | (issue_valid & issue_ready):
//    - With a candidate present: issue_index = selected slot, issue_valid=1, and that slot -> ISSUED at the same edge.
//    - Otherwise: issue_valid -> 0.
//  - Handshake rule: while issue_valid & !issue_ready, issue_valid and issue_index hold stable.
//  - Latency: a zero-dep instruction allocated in cycle t becomes WAIT in t+1; issue_valid=1 with its index in t+2.
//  - Producer done in cycle t releases a consumer. The consumer can appear on issue in t+2.
//  - occupancy: +1 on alloc fire, -1 on effective done, unchanged when both occur in the same cycle.
//  - Full: alloc_ready=0, and alloc_valid is ignored.
//  - Empty: occupancy=0, issue_valid=0 once the issue reg drains.
//  - Reset (any cycle, including mid-issue):
//    - All slots FREE, all dep rows 0.
//    - issue_valid=0, issue_index=0, occupancy=0.
//    - alloc_ready=1, alloc_index=0.
//    - The instruction in the issue reg is discarded.
// CONFIGURATION
//  - ISSUE_SCHED_RR_EN undefined: fixed priority; the lowest-index candidate is selected.
//  - ISSUE_SCHED_RR_EN defined: round-robin selection.
//    - A $clog2(bs) pointer rr_ptr, reset 0.
//    - Selection = first candidate at index >= rr_ptr, wrapping modulo bs.
//    - On each load of the issue reg with a candidate, rr_ptr = selected index + 1 (mod bs).
//    - Avoids starvation of high slots.
// TESTING
//  - Reset, then alloc 3 independent instrs (dept=0) back-to-back with issue_ready=1:
//    -> alloc_index 0,1,2; issue_index 0,1,2 in cycles t+2..t+4; occupancy 3.
//  - Alloc slot0; alloc slot1 with dept bit0=1; done slot0 two cycles after slot0 issues:
//    -> slot1 issue_valid exactly 2 cycles after done.
//  - Fill all 32 slots with issue_ready=0:
//    -> alloc_ready=0 and occupancy=32 after the 32nd fire.
//    -> issue_valid=1 with index 0, held stable throughout.
//  - Same-cycle alloc + done on a full buffer (done slot 5, alloc_valid=1):
//    -> no alloc that cycle; next cycle alloc_index=5; occupancy net unchanged on a same-cycle fire.
//  - Assert rst while issue_valid=1 and 10 slots live:
//    -> next cycle all outputs at reset values; a following alloc gets index 0.
//  - ISSUE_SCHED_RR_EN: slots 0 and 3 both ready with rr_ptr=2
//    -> slot 3 issues first, then slot 0; without the macro, slot 0 issues first.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - alloc/issue/done handshake bundle for issue_scheduler
interface issue_scheduler_if #(
    parameter int bs = 32
);
    localparam int IW = $clog2(bs);

    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] alloc_index;
    logic [0:bs-1] alloc_dept;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_index;
    logic          done_valid;
    logic [IW-1:0] done_index;
    logic [IW:0]   occupancy;

    modport master (
        output alloc_valid, alloc_dept, issue_ready, done_valid, done_index,
        input  alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_dept, issue_ready, done_valid, done_index,
        output alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - slot allocator and dependency-aware issue scheduler
// Define ISSUE_SCHED_RR_EN for round-robin issue selection; default is lowest-index first.
module issue_scheduler #(
    parameter int bs = 32
) (
    input  logic             clk,
    input  logic             rst,
    issue_scheduler_if.slave bus
);
    localparam int IW = $clog2(bs);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_ISSUED} slot_t;

    slot_t         st_q  [bs];
    slot_t         st_d  [bs];
    logic [0:bs-1] dep_q [bs];
    logic [0:bs-1] dep_d [bs];
    logic          issue_valid_q, issue_valid_d;
    logic [IW-1:0] issue_index_q, issue_index_d;
    logic [IW:0]   occ_q, occ_d;

    logic [0:bs-1] live, cand, self_mask, done_mask, done_col, alloc_row;
    logic          free_found, sel_found, done_eff, alloc_fire, load;
    logic [IW-1:0] free_idx, sel_idx;

`ifdef ISSUE_SCHED_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    int            j;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                st_q[i]  <= S_FREE;
                dep_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            occ_q         <= '0;
`ifdef ISSUE_SCHED_RR_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            for (int i = 0; i < bs; i++) begin
                st_q[i]  <= st_d[i];
                dep_q[i] <= dep_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            occ_q         <= occ_d;
`ifdef ISSUE_SCHED_RR_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    // Decode of registered state: free slot, candidates, selection, masks
    always_comb begin
        live       = '0;
        cand       = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < bs; i++) begin
            live[i] = (st_q[i] != S_FREE);
            cand[i] = (st_q[i] == S_WAIT) && (dep_q[i] == '0);
        end
        for (int i = bs - 1; i >= 0; i--) begin
            if (!live[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
`ifdef ISSUE_SCHED_RR_EN
        j = 0;
        // Descending offset so the nearest candidate at or after rr_ptr wins
        for (int k = bs - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= bs) j = j - bs;
            if (cand[IW'(j)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
`else
        for (int i = bs - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
`endif
        done_eff   = bus.done_valid && (st_q[bus.done_index] == S_ISSUED);
        alloc_fire = bus.alloc_valid && free_found;
        load       = !issue_valid_q || bus.issue_ready;
        for (int i = 0; i < bs; i++) begin
            self_mask[i] = (IW'(i) == free_idx);
            done_mask[i] = bus.done_valid && (IW'(i) == bus.done_index);
            done_col[i]  = done_eff && (IW'(i) == bus.done_index);
        end
        alloc_row = bus.alloc_dept & live & ~self_mask & ~done_mask;
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < bs; i++) begin
            st_d[i]  = st_q[i];
            dep_d[i] = dep_q[i] & ~done_col;
            if (done_eff && (IW'(i) == bus.done_index)) st_d[i] = S_FREE;
            if (load && sel_found && (IW'(i) == sel_idx)) st_d[i] = S_ISSUED;
            if (alloc_fire && (IW'(i) == free_idx)) begin
                st_d[i]  = S_WAIT;
                dep_d[i] = alloc_row;
            end
        end
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
`ifdef ISSUE_SCHED_RR_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        if (load) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_index_d = sel_idx;
`ifdef ISSUE_SCHED_RR_EN
                rr_ptr_d = (sel_idx == IW'(bs - 1)) ? '0 : sel_idx + 1'b1;
`endif
            end
        end
        occ_d = occ_q + (IW + 1)'(alloc_fire) - (IW + 1)'(done_eff);
    end

    // Outputs
    assign bus.alloc_ready = free_found;
    assign bus.alloc_index = free_idx;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_index = issue_index_q;
    assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler
module tb_issue_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_q[$];
    logic [0:31] d;

    always #5 clk = ~clk;

    issue_scheduler_if #(.bs(32)) bus ();
    issue_scheduler #(.bs(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Issue-side monitor: every accepted issue is matched against the scoreboard
    always @(negedge clk) begin : monitor
        int e;
        if (!rst && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_issue: got %0d expected none", bus.issue_index);
            end else begin
                e = exp_q.pop_front();
                chk("issue_order", int'(bus.issue_index), e);
            end
        end
    end

    task automatic drive(input logic av, input logic [0:31] dv_dept, input logic dv, input int di);
        bus.alloc_valid = av;
        bus.alloc_dept  = dv_dept;
        bus.done_valid  = dv;
        bus.done_index  = 5'(di);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.issue_ready = 1'b0;
        idle();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_alloc_ready", int'(bus.alloc_ready), 1);
        chk("rst_alloc_index", int'(bus.alloc_index), 0);
        chk("rst_issue_valid", int'(bus.issue_valid), 0);
        chk("rst_issue_index", int'(bus.issue_index), 0);
        chk("rst_occupancy", int'(bus.occupancy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        mid(); chk_reset_vals(); nxt();

        // Three independent instructions back-to-back
        bus.issue_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, '0, 1'b0, 0);
            mid();
            chk("t1_alloc_index", int'(bus.alloc_index), i);
            if (i == 2) begin
                chk("t1_first_issue_valid", int'(bus.issue_valid), 1);
                chk("t1_first_issue_index", int'(bus.issue_index), 0);
            end
            nxt();
        end
        idle(); mid();
        chk("t1_occupancy", int'(bus.occupancy), 3);
        chk("t1_issue_index_1", int'(bus.issue_index), 1);
        nxt();
        mid(); chk("t1_issue_index_2", int'(bus.issue_index), 2); nxt();
        mid(); chk("t1_drained", int'(bus.issue_valid), 0); nxt();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, i); mid(); nxt();
        end
        idle(); mid(); chk("t1_occ_empty", int'(bus.occupancy), 0); nxt();

        // Producer/consumer wake-up latency
        do_reset();
        bus.issue_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
        drive(1'b1, '0, 1'b0, 0); mid(); nxt();
        d = '0; d[0] = 1'b1;
        drive(1'b1, d, 1'b0, 0); mid(); chk("t2_alloc_index", int'(bus.alloc_index), 1); nxt();
        idle(); mid();
        chk("t2_prod_valid", int'(bus.issue_valid), 1);
        chk("t2_prod_index", int'(bus.issue_index), 0);
        nxt();
        mid(); chk("t2_blocked_a", int'(bus.issue_valid), 0); nxt();
        drive(1'b0, '0, 1'b1, 0); mid(); chk("t2_blocked_b", int'(bus.issue_valid), 0); nxt();
        idle(); mid(); chk("t2_blocked_c", int'(bus.issue_valid), 0); nxt();
        mid();
        chk("t2_cons_valid", int'(bus.issue_valid), 1);
        chk("t2_cons_index", int'(bus.issue_index), 1);
        nxt();
        drive(1'b0, '0, 1'b1, 1); mid(); nxt();
        idle(); mid(); chk("t2_occ_empty", int'(bus.occupancy), 0); nxt();

        // Fill all 32 slots with the execution unit stalled
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, '0, 1'b0, 0);
            mid();
            chk("t3_alloc_index", int'(bus.alloc_index), i);
            if (i >= 2) begin
                chk("t3_hold_valid", int'(bus.issue_valid), 1);
                chk("t3_hold_index", int'(bus.issue_index), 0);
            end
            nxt();
        end
        drive(1'b1, '0, 1'b0, 0); mid();
        chk("t3_full_ready", int'(bus.alloc_ready), 0);
        chk("t3_full_occ", int'(bus.occupancy), 32);
        chk("t3_full_index", int'(bus.issue_index), 0);
        nxt();
        mid(); chk("t3_full_ignored", int'(bus.occupancy), 32); nxt();

        // Let slots 0..5 issue, then same-cycle alloc + done on the full buffer
        idle();
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(i);
        for (int i = 0; i < 6; i++) begin
            mid(); nxt();
        end
        bus.issue_ready = 1'b0;
        drive(1'b1, '0, 1'b1, 5); mid(); chk("t4_no_alloc", int'(bus.alloc_ready), 0); nxt();
        idle(); mid();
        chk("t4_ready_after", int'(bus.alloc_ready), 1);
        chk("t4_index_after", int'(bus.alloc_index), 5);
        chk("t4_occ_after", int'(bus.occupancy), 31);
        nxt();
        drive(1'b1, '0, 1'b1, 0); mid(); chk("t4_alloc_index", int'(bus.alloc_index), 5); nxt();
        idle(); mid();
        chk("t4_occ_net", int'(bus.occupancy), 31);
        chk("t4_next_free", int'(bus.alloc_index), 0);
        nxt();

        // Reset while issuing with 10 live slots
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, '0, 1'b0, 0); mid(); nxt();
        end
        idle(); mid();
        chk("t5_pre_valid", int'(bus.issue_valid), 1);
        chk("t5_pre_occ", int'(bus.occupancy), 10);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        drive(1'b1, '0, 1'b0, 0); mid(); chk_reset_vals(); nxt();
        idle(); mid();
        chk("t5_post_occ", int'(bus.occupancy), 1);
        chk("t5_post_index", int'(bus.alloc_index), 1);
        nxt();

        // Selection policy with slots 0 and 3 released together and rr_ptr at 2
        do_reset();
        bus.issue_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
`ifdef ISSUE_SCHED_RR_EN
        exp_q.push_back(3); exp_q.push_back(0);
`else
        exp_q.push_back(0); exp_q.push_back(3);
`endif
        exp_q.push_back(2);
        drive(1'b1, '0, 1'b0, 0); mid(); nxt();
        drive(1'b1, '0, 1'b0, 0); mid(); nxt();
        idle(); mid(); nxt();
        mid(); nxt();
        drive(1'b0, '0, 1'b1, 0); mid(); nxt();
        d = '0; d[1] = 1'b1;
        drive(1'b1, d, 1'b0, 0); mid(); chk("t6_alloc0", int'(bus.alloc_index), 0); nxt();
        d = '0; d[0] = 1'b1; d[1] = 1'b1;
        drive(1'b1, d, 1'b0, 0); mid(); chk("t6_alloc2", int'(bus.alloc_index), 2); nxt();
        d = '0; d[1] = 1'b1;
        drive(1'b1, d, 1'b0, 0); mid(); chk("t6_alloc3", int'(bus.alloc_index), 3); nxt();
        drive(1'b0, '0, 1'b1, 1); mid(); nxt();
        idle(); mid(); nxt();
        mid();
        chk("t6_first_valid", int'(bus.issue_valid), 1);
`ifdef ISSUE_SCHED_RR_EN
        chk("t6_first_index", int'(bus.issue_index), 3);
`else
        chk("t6_first_index", int'(bus.issue_index), 0);
`endif
        nxt();
        mid(); nxt();
        mid(); nxt();
        mid(); nxt();
        drive(1'b0, '0, 1'b1, 0); mid(); nxt();
        idle(); mid(); nxt();
        mid(); nxt();
        drive(1'b0, '0, 1'b1, 3); mid(); nxt();
        drive(1'b0, '0, 1'b1, 2); mid(); nxt();
        idle(); mid();
        chk("t6_occ_empty", int'(bus.occupancy), 0);
        chk("t6_issue_idle", int'(bus.issue_valid), 0);
        nxt();

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
